pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised next-PC generator with its own architectural PC register, replacing the purely combinational next-PC select. Picks among sequential, branch, JAL and JALR targets. Holds the PC under stall or fetch back-pressure, and latches a redirect that arrives during a hold so it is not lost. Sits between the execute-stage target adders and the instruction-memory address port.

Parameters:
PC_W, 12, width of the PC register and instruction-memory address.
RESET_PC, 0, PC value loaded on reset; truncated to PC_W.
PC_INC, 4, sequential increment in bytes.

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  reset, asynchronous, active-low
target_branch  in  32  branch target
target_jal  in  32  JAL target
target_jalr  in  32  JALR target; bit 0 cleared internally
pc_src  in  3  select: 000 seq, 001 branch, 110 JAL, 100 JALR
stall  in  1  pipeline stall; PC must hold
fetch_ready  in  1  instruction memory accepts address this cycle
pc  out  PC_W  current fetch PC (registered)
fetch_valid  out  1  pc is a valid fetch request
redirect_pulse  out  1  one-cycle pulse when a non-sequential target is loaded into pc
misalign  out  1  misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (RSTn=0, asynchronous): pc=RESET_PC[PC_W-1:0], fetch_valid=0, redirect_pulse=0, misalign=0, pending register cleared, state=BOOT.
- States:
  - BOOT: one cycle after reset release; fetch_valid=0; always goes to RUN.
  - RUN: fetch_valid=1.
  - HOLD: fetch_valid=1, pc frozen.
- advance = fetch_valid & fetch_ready & ~stall.
- RUN:
  - If advance, pc <= selected target; state stays RUN.
  - Else state -> HOLD. A redirect presented in the same cycle goes to the pending register.
- HOLD:
  - If pc_src != 000, latch the target into the pending register; a later redirect overwrites an earlier one (newest wins).
  - When advance becomes 1: if pending is valid, pc <= pending target and pending is cleared; otherwise pc <= selected target. State -> RUN.
  - If a live pc_src redirect and a pending redirect coexist on the release cycle, the live one wins.
- Target selection:
  - seq = pc + PC_INC, modulo 2^PC_W; wraps to 0 at the top.
  - Targets are truncated to [PC_W-1:0].
  - Undefined pc_src codes are treated as seq.
- redirect_pulse: 1 in the cycle after pc loads a non-seq or pending target; otherwise 0.
- Latency: a target is visible on pc one cycle after the accepting edge.
- Reset mid-hold discards the pending target.

Optional Feature:
PC_ALIGN_CHK_EN
- Defined:
  - A selected non-seq target with bits [1:0] != 0 (after JALR bit-0 clear) is not loaded; pc holds.
  - misalign is registered high and stays sticky until reset.
  - While misalign=1, fetch_valid=0 and advance is blocked.
- Undefined: target bits [1:0] are forced to 0 and misalign is tied to 0.

Decomposition:
- Shared package holds:
  - pc_src encodings: PCSRC_SEQ=3'b000, PCSRC_BR=3'b001, PCSRC_JAL=3'b110, PCSRC_JALR=3'b100.
  - State enum: BOOT, RUN, HOLD.
  - Default PC_W and PC_INC constants.
- One sub-module: pc_target_sel. Combinational; selects the target, truncates it and clears JALR bit 0. It is the successor to the old next-PC select.
- The pending register and FSM stay in the top.

Test Plan:
- Reset then release, fetch_ready=1, stall=0, pc_src=000 -> pc=0 with fetch_valid=0 for one cycle, then fetch_valid=1 and pc sequence 0, 4, 8, 12.
- pc=0x010, pc_src=110, target_jal=0x1F0, advance -> pc=0x1F0 next cycle; redirect_pulse high exactly one cycle.
- stall=1 at pc=0x020:
  - Cycle 1: branch to 0x100.
  - Cycle 2: JALR to 0x0C1.
  - Release stall with pc_src=000 -> pc=0x0C0 (newest pending wins, bit 0 cleared), then 0x0C4.
- PC_W=12, pc=0xFFC, seq advance -> pc=0x000 (wrap), redirect_pulse=0.
- fetch_ready=0 for 3 cycles with branch pending, RSTn pulsed low in cycle 2 -> pc=RESET_PC immediately, pending discarded, BOOT then seq from RESET_PC.
- PC_ALIGN_CHK_EN: JAL to 0x102 -> pc holds, misalign=1, fetch_valid=0 until reset. Without the macro -> pc=0x100, misalign=0.

Source files
------------

// File: rtl/pc_gen_unit_pkg.sv
// Shared encodings, FSM states and defaults for the PC generator.
// Optional feature macro: PC_ALIGN_CHK_EN.
package pc_gen_unit_pkg;

  localparam logic [2:0] PCSRC_SEQ  = 3'b000;
  localparam logic [2:0] PCSRC_BR   = 3'b001;
  localparam logic [2:0] PCSRC_JAL  = 3'b110;
  localparam logic [2:0] PCSRC_JALR = 3'b100;

  localparam int DEF_PC_W   = 12;
  localparam int DEF_PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Target/select inputs and fetch handshake of the PC generator.
// Optional feature macro: PC_ALIGN_CHK_EN.
interface pc_gen_unit_if
  import pc_gen_unit_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
);
  logic [31:0]     target_branch;
  logic [31:0]     target_jal;
  logic [31:0]     target_jalr;
  logic [2:0]      pc_src;
  logic            stall;
  logic            fetch_ready;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            redirect_pulse;
  logic            misalign;

  modport master (
    output target_branch, target_jal, target_jalr,
    output pc_src, stall, fetch_ready,
    input  pc, fetch_valid, redirect_pulse, misalign
  );

  modport slave (
    input  target_branch, target_jal, target_jalr,
    input  pc_src, stall, fetch_ready,
    output pc, fetch_valid, redirect_pulse, misalign
  );

endinterface

// File: rtl/pc_gen_unit_target_sel.sv
// Combinational next-PC target select (successor of the old next-PC mux).
// Optional feature macro: PC_ALIGN_CHK_EN.
module pc_target_sel
  import pc_gen_unit_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int PC_INC = DEF_PC_INC
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      pc_src,
  input  logic [31:0]     target_branch,
  input  logic [31:0]     target_jal,
  input  logic [31:0]     target_jalr,
  output logic [PC_W-1:0] tgt,
  output logic            redir
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  logic            is_br;
  logic            is_jal;
  logic            is_jalr;
  logic [PC_W-1:0] raw;
  logic            unused_bits;

  assign unused_bits = ^{target_branch, target_jal, target_jalr};

  always_comb begin
    is_br   = (pc_src == PCSRC_BR);
    is_jal  = (pc_src == PCSRC_JAL);
    is_jalr = (pc_src == PCSRC_JALR);
    raw     = pc + INC;
    redir   = 1'b0;
    unique case (1'b1)
      is_br: begin
        raw   = target_branch[PC_W-1:0];
        redir = 1'b1;
      end
      is_jal: begin
        raw   = target_jal[PC_W-1:0];
        redir = 1'b1;
      end
      is_jalr: begin
        raw   = {target_jalr[PC_W-1:1], 1'b0};
        redir = 1'b1;
      end
      default: ;
    endcase
`ifdef PC_ALIGN_CHK_EN
    tgt = raw;
`else
    // silently realign redirect targets when nothing checks them
    tgt = redir ? {raw[PC_W-1:2], 2'b00} : raw;
`endif
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Registered PC generator: FSM, pending redirect latch, fetch handshake.
// Optional feature macro: PC_ALIGN_CHK_EN (sticky misaligned-target trap).
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int          PC_W     = DEF_PC_W,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          PC_INC   = DEF_PC_INC
) (
  input  logic          CLK,
  input  logic          RSTn,
  pc_gen_unit_if.slave  bus
);

  localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [PC_W-1:0] sel_tgt, ld_tgt;
  logic            pend_v_q, pend_v_d;
  logic            pulse_q, pulse_d;
  logic            mis_q, mis_d;
  logic            sel_redir, ld_redir, ld_bad;
  logic            fetch_valid, advance;

  pc_target_sel #(
    .PC_W   (PC_W),
    .PC_INC (PC_INC)
  ) u_sel (
    .pc            (pc_q),
    .pc_src        (bus.pc_src),
    .target_branch (bus.target_branch),
    .target_jal    (bus.target_jal),
    .target_jalr   (bus.target_jalr),
    .tgt           (sel_tgt),
    .redir         (sel_redir)
  );

  assign fetch_valid = (state_q != BOOT) & ~mis_q;
  assign advance = fetch_valid & bus.fetch_ready & ~bus.stall;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    pulse_d  = 1'b0;
    mis_d    = mis_q;
    ld_tgt   = sel_tgt;
    ld_redir = sel_redir;
    // a live redirect beats the latched one on release
    if (state_q == HOLD && !sel_redir && pend_v_q) begin
      ld_tgt   = pend_q;
      ld_redir = 1'b1;
    end
`ifdef PC_ALIGN_CHK_EN
    ld_bad = ld_redir & (ld_tgt[1:0] != 2'b00);
`else
    ld_bad = 1'b0;
`endif
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (advance) begin
          state_d  = RUN;
          pend_v_d = 1'b0;
          if (ld_bad) begin
            mis_d = 1'b1;
          end else begin
            pc_d    = ld_tgt;
            pulse_d = ld_redir;
          end
        end else begin
          state_d = HOLD;
          if (sel_redir) begin
            pend_d   = sel_tgt;
            pend_v_d = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= BOOT;
      pc_q     <= RST_PC;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      pulse_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      pulse_q  <= pulse_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.fetch_valid    = fetch_valid;
  assign bus.redirect_pulse = pulse_q;
  assign bus.misalign       = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit (PC_W=12, RESET_PC=0, PC_INC=4).
// Expectations follow PC_ALIGN_CHK_EN when the build defines it.
module tb_pc_gen_unit;
  import pc_gen_unit_pkg::*;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] tgt;
    logic        st;
    logic        fr;
    logic [11:0] epc;
    logic        ep;
  } stim_t;

  typedef struct {
    logic [11:0] pc;
    logic        p;
    logic        fv;
    logic        mis;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  pc_gen_unit_if #(.PC_W(12)) bus();

  pc_gen_unit #(
    .PC_W     (12),
    .RESET_PC (32'h0),
    .PC_INC   (4)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic drive(input stim_t s);
    bus.pc_src = s.src;
    bus.stall = s.st;
    bus.fetch_ready = s.fr;
    bus.target_branch = (s.src == PCSRC_BR) ? s.tgt : 32'h0000_0A00;
    bus.target_jal = (s.src == PCSRC_JAL) ? s.tgt : 32'h0000_0B00;
    bus.target_jalr = (s.src == PCSRC_JALR) ? s.tgt : 32'h0000_0E00;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e;
    drive('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h0, 1'b0});
    RSTn = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (bus.pc !== 12'h0 || bus.fetch_valid !== 1'b0 ||
        bus.redirect_pulse !== 1'b0 || bus.misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: pc=%h fv=%b p=%b mis=%b, want 000 0 0 0",
               bus.pc, bus.fetch_valid, bus.redirect_pulse, bus.misalign);
    end
    RSTn = 1'b1;
    #1;
    total++;
    if (bus.pc !== 12'h0 || bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL boot_cycle: pc=%h fv=%b, want 000 0",
               bus.pc, bus.fetch_valid);
    end
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h000, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h004, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h008, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h00C, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h010, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      sbq.push_back('{s[i].epc, s[i].ep, 1'b1, 1'b0});
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL seq step %0d: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid,
                 e.pc, e.p, e.fv);
      end
    end
  endtask

  task automatic test_jal();
    stim_t s[$];
    exp_t  e;
    s.push_back('{PCSRC_JAL, 32'h1F0, 1'b0, 1'b1, 12'h1F0, 1'b1});
    s.push_back('{PCSRC_SEQ, 32'h0,   1'b0, 1'b1, 12'h1F4, 1'b0});
    s.push_back('{PCSRC_BR,  32'h020, 1'b0, 1'b1, 12'h020, 1'b1});
    foreach (s[i]) begin
      drive(s[i]);
      sbq.push_back('{s[i].epc, s[i].ep, 1'b1, 1'b0});
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL jal step %0d: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid,
                 e.pc, e.p, e.fv);
      end
    end
  endtask

  task automatic test_stall_pending();
    stim_t s[$];
    exp_t  e;
    s.push_back('{PCSRC_BR,   32'h100, 1'b1, 1'b1, 12'h020, 1'b0});
    s.push_back('{PCSRC_JALR, 32'h0C1, 1'b1, 1'b1, 12'h020, 1'b0});
    s.push_back('{PCSRC_SEQ,  32'h0,   1'b0, 1'b1, 12'h0C0, 1'b1});
    s.push_back('{PCSRC_SEQ,  32'h0,   1'b0, 1'b1, 12'h0C4, 1'b0});
    s.push_back('{PCSRC_BR,   32'h200, 1'b1, 1'b1, 12'h0C4, 1'b0});
    s.push_back('{PCSRC_JAL,  32'h240, 1'b0, 1'b1, 12'h240, 1'b1});
    s.push_back('{PCSRC_SEQ,  32'h0,   1'b0, 1'b1, 12'h244, 1'b0});
    s.push_back('{PCSRC_SEQ,  32'h0,   1'b0, 1'b0, 12'h244, 1'b0});
    s.push_back('{PCSRC_SEQ,  32'h0,   1'b0, 1'b1, 12'h248, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      sbq.push_back('{s[i].epc, s[i].ep, 1'b1, 1'b0});
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL hold step %0d: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid,
                 e.pc, e.p, e.fv);
      end
    end
  endtask

  task automatic test_wrap_sel();
    stim_t s[$];
    exp_t  e;
    s.push_back('{PCSRC_JAL,  32'h0FF8,    1'b0, 1'b1, 12'hFF8, 1'b1});
    s.push_back('{PCSRC_SEQ,  32'h0,       1'b0, 1'b1, 12'hFFC, 1'b0});
    s.push_back('{PCSRC_SEQ,  32'h0,       1'b0, 1'b1, 12'h000, 1'b0});
    s.push_back('{PCSRC_JAL,  32'h0001_2344, 1'b0, 1'b1, 12'h344, 1'b1});
    s.push_back('{3'b111,     32'h0,       1'b0, 1'b1, 12'h348, 1'b0});
    s.push_back('{3'b010,     32'h0,       1'b0, 1'b1, 12'h34C, 1'b0});
    s.push_back('{PCSRC_JALR, 32'h0479,    1'b0, 1'b1, 12'h478, 1'b1});
    s.push_back('{PCSRC_BR,   32'h05A4,    1'b0, 1'b1, 12'h5A4, 1'b1});
    foreach (s[i]) begin
      drive(s[i]);
      sbq.push_back('{s[i].epc, s[i].ep, 1'b1, 1'b0});
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL wrap_sel step %0d: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid,
                 e.pc, e.p, e.fv);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    stim_t s[$];
    exp_t  e;
    drive('{PCSRC_BR, 32'h500, 1'b0, 1'b0, 12'h0, 1'b0});
    sbq.push_back('{12'h5A4, 1'b0, 1'b1, 1'b0});
    @(posedge CLK); #1;
    e = sbq.pop_front();
    total++;
    if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
        bus.fetch_valid !== e.fv) begin
      bad++;
      $display("FAIL bp_hold: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
               bus.pc, bus.redirect_pulse, bus.fetch_valid, e.pc, e.p, e.fv);
    end
    drive('{PCSRC_SEQ, 32'h0, 1'b0, 1'b0, 12'h0, 1'b0});
    #2 RSTn = 1'b0;
    #1;
    total++;
    if (bus.pc !== 12'h000 || bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: pc=%h fv=%b, want 000 0",
               bus.pc, bus.fetch_valid);
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h000, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h004, 1'b0});
    s.push_back('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h008, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      sbq.push_back('{s[i].epc, s[i].ep, 1'b1, 1'b0});
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL post_reset step %0d: pc=%h p=%b fv=%b, want pc=%h p=%b fv=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid,
                 e.pc, e.p, e.fv);
      end
    end
  endtask

  task automatic test_align();
    exp_t e;
    drive('{PCSRC_JAL, 32'h102, 1'b0, 1'b1, 12'h0, 1'b0});
`ifdef PC_ALIGN_CHK_EN
    sbq.push_back('{12'h008, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{12'h008, 1'b0, 1'b0, 1'b1});
`else
    sbq.push_back('{12'h100, 1'b1, 1'b1, 1'b0});
    sbq.push_back('{12'h104, 1'b0, 1'b1, 1'b0});
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      e = sbq.pop_front();
      total++;
      if (bus.pc !== e.pc || bus.redirect_pulse !== e.p ||
          bus.fetch_valid !== e.fv || bus.misalign !== e.mis) begin
        bad++;
        $display("FAIL align step %0d: pc=%h p=%b fv=%b mis=%b, want pc=%h p=%b fv=%b mis=%b",
                 i, bus.pc, bus.redirect_pulse, bus.fetch_valid, bus.misalign,
                 e.pc, e.p, e.fv, e.mis);
      end
      drive('{PCSRC_SEQ, 32'h0, 1'b0, 1'b1, 12'h0, 1'b0});
    end
    RSTn = 1'b0;
    #1;
    total++;
    if (bus.misalign !== 1'b0 || bus.pc !== 12'h000) begin
      bad++;
      $display("FAIL align_reset: mis=%b pc=%h, want 0 000",
               bus.misalign, bus.pc);
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_jal();
    test_stall_pending();
    test_wrap_sel();
    test_reset_mid_hold();
    test_align();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: size=%0d, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
